// File: rtl/ibus_dbus_arbiter.sv
// rtl/ibus_dbus_arbiter.sv - single-bus arbiter between instruction fetch and memory access
//
// Purpose: grants one external bus to either the IF or the MEM requester,
// registers every bus output, returns read data with a one-cycle ack pulse,
// aborts stuck transactions after TIMEOUT wait cycles and raises pipeline
// stall requests while a requester is waiting.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   if_req/if_addr                IF fetch request (held until if_ack or flush)
//   if_rdata/if_ack               fetched word and its one-cycle completion pulse
//   mem_req/we/sel/addr/wdata     MEM request and qualifiers (held until mem_ack)
//   mem_rdata/mem_ack             MEM read word and its one-cycle completion pulse
//   flush                         cancels delivery of an in-flight IF result
//   bus_req/we/sel/addr/wdata     registered bus request and qualifiers
//   bus_rdata/bus_ack             bus read data and completion
//   bus_err                       one-cycle pulse when a transaction times out
//   stallreq_from_if/_mem         combinational stall requests to the pipeline

module ibus_dbus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  input  logic              flush,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err,
  output logic              stallreq_from_if,
  output logic              stallreq_from_mem
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEM_BUS = 2'd1;
  localparam logic [1:0] S_IF_BUS  = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [1:0]        r_state;
  logic [7:0]        r_wait_cnt;
  logic              r_discard;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [3:0]        r_bus_sel;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic              r_bus_err;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_if_ack;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_mem_ack;

  logic [7:0]        w_cnt_next;
  logic              w_timeout;
  logic              w_if_discard;

  assign w_cnt_next   = r_wait_cnt + 8'd1;
  assign w_timeout    = (w_cnt_next == TIMEOUT_CNT);
  // A flush in the completing cycle must also suppress the result.
  assign w_if_discard = r_discard | flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_discard   <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_err   <= 1'b0;
      r_if_rdata  <= '0;
      r_if_ack    <= 1'b0;
      r_mem_rdata <= '0;
      r_mem_ack   <= 1'b0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // MEM holds the older instruction, so it always wins a tie.
          if (mem_req) begin
            r_state     <= S_MEM_BUS;
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_we;
            r_bus_sel   <= mem_sel;
            r_bus_addr  <= mem_addr;
            r_bus_wdata <= mem_wdata;
            r_wait_cnt  <= '0;
          end else if (if_req && !flush) begin
            r_state     <= S_IF_BUS;
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'b1111;
            r_bus_addr  <= if_addr;
            r_bus_wdata <= '0;
            r_wait_cnt  <= '0;
            r_discard   <= 1'b0;
          end
        end
        S_MEM_BUS: begin
          if (bus_ack) begin
            r_mem_rdata <= bus_rdata;
            r_mem_ack   <= 1'b1;
            r_bus_req   <= 1'b0;
            r_state     <= S_DONE;
          end else if (w_timeout) begin
            r_mem_rdata <= '0;
            r_mem_ack   <= 1'b1;
            r_bus_err   <= 1'b1;
            r_bus_req   <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_wait_cnt  <= w_cnt_next;
          end
        end
        S_IF_BUS: begin
          // The bus cannot abort, so a flushed fetch still runs to completion
          // and only the delivery to IF is dropped.
          if (bus_ack || w_timeout) begin
            if (!w_if_discard) begin
              r_if_rdata <= bus_ack ? bus_rdata : '0;
              r_if_ack   <= 1'b1;
            end
            r_bus_err <= ~bus_ack;
            r_bus_req <= 1'b0;
            r_discard <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_wait_cnt <= w_cnt_next;
            r_discard  <= w_if_discard;
          end
        end
        S_DONE: begin
          // One guaranteed idle bus cycle between transactions.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_sel   = r_bus_sel;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_err   = r_bus_err;
  assign if_rdata  = r_if_rdata;
  assign if_ack    = r_if_ack;
  assign mem_rdata = r_mem_rdata;
  assign mem_ack   = r_mem_ack;

  assign stallreq_from_if  = if_req & ~r_if_ack & ~flush;
  assign stallreq_from_mem = mem_req & ~r_mem_ack;

endmodule

// File: doc/ibus_dbus_arbiter.md
Name: ibus_dbus_arbiter

Overview:
- Shares the single external memory bus between the instruction-fetch stage (IF) and the memory-access stage (MEM).
- Grants the bus to one requester at a time, registers all bus outputs, and returns read data with a one-cycle ack pulse.
- Raises stall requests that feed the pipeline stall controller, so the pipeline freezes while a requester is waiting.
- Sits between the pipeline and the memory bus interface.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- TIMEOUT, 255, maximum bus-wait cycles before a transaction is aborted; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  IF read request; held with if_addr until if_ack or flush.
- if_addr  in  ADDR_W  IF fetch address.
- if_rdata  out  DATA_W  fetched instruction; valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse to IF.
- mem_req  in  1  MEM request; held stable with its qualifiers until mem_ack.
- mem_we  in  1  1=write, 0=read.
- mem_sel  in  4  byte enables.
- mem_addr  in  ADDR_W  MEM address.
- mem_wdata  in  DATA_W  MEM write data.
- mem_rdata  out  DATA_W  MEM read data; valid while mem_ack=1.
- mem_ack  out  1  one-cycle completion pulse to MEM.
- flush  in  1  pipeline flush; cancels delivery of an in-flight IF result.
- bus_req  out  1  bus transaction request (registered).
- bus_we  out  1  bus write enable (registered).
- bus_sel  out  4  bus byte enables (registered).
- bus_addr  out  ADDR_W  bus address (registered).
- bus_wdata  out  DATA_W  bus write data (registered).
- bus_rdata  in  DATA_W  bus read data; sampled only when bus_ack=1.
- bus_ack  in  1  bus completion; honoured only while bus_req=1.
- bus_err  out  1  one-cycle pulse on timeout abort.
- stallreq_from_if  out  1  combinational: if_req & ~if_ack & ~flush.
- stallreq_from_mem  out  1  combinational: mem_req & ~mem_ack.

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; every registered output, the discard flag and the wait counter go to 0. Deassertion takes effect at the next clock edge.
- Reset asserted mid-transaction: bus_req drops immediately and no ack is issued.
- FSM states: IDLE, MEM_BUS, IF_BUS, DONE.
- IDLE, mem_req=1: go to MEM_BUS. Load bus_addr/we/sel/wdata from the MEM inputs; bus_req=1.
- IDLE, mem_req=0 and if_req=1 and flush=0: go to IF_BUS. bus_addr=if_addr, bus_we=0, bus_sel=4'b1111, bus_wdata=0, bus_req=1.
- Priority: MEM always wins over IF. MEM holds the older instruction, so a simultaneous request grants MEM.
- Latency: grant decided in IDLE, bus_req visible the next cycle.
- MEM_BUS/IF_BUS, bus_ack=1:
  - Capture bus_rdata into mem_rdata or if_rdata.
  - Pulse the matching ack for exactly one cycle (the cycle after bus_ack).
  - bus_req=0; go to DONE.
- DONE: lasts one cycle, with bus_req kept low, so back-to-back transactions are separated by at least one idle bus cycle. Then return to IDLE.
- Minimum turnaround request to ack is 3 cycles, with zero-wait bus_ack.
- Wait counter:
  - Cleared when a grant is issued; increments each cycle in MEM_BUS or IF_BUS with bus_ack=0.
  - When it reaches TIMEOUT: bus_req=0, bus_err pulses for one cycle, and the matching ack pulses with rdata=0 so the pipeline never deadlocks. Then go to DONE.
  - A bus_ack in the same cycle the counter reaches TIMEOUT counts as a normal completion, not an abort.
- Flush:
  - Asserted during IF_BUS (or coincident with the IF grant): set the discard flag. The bus transaction still completes, since the bus cannot abort, but if_ack is suppressed and if_rdata is unchanged.
  - The discard flag clears on entry to DONE.
  - Flush has no effect on MEM transactions.
  - While flush=1, IDLE does not grant IF.
- Outputs hold: if_rdata and mem_rdata keep their last captured value outside their ack cycle. Bus outputs other than bus_req keep their values until the next grant.
- A bus_ack arriving while bus_req=0 is ignored.

Test Plan:
- Reset release, if_req=1, if_addr=0x0000_0100, bus_ack returned 1 cycle after bus_req with bus_rdata=0x2401_0005 -> bus_req high 1 cycle after grant; if_ack pulses once with if_rdata=0x2401_0005; stallreq_from_if high until the ack cycle.
- if_req and mem_req both asserted in the same cycle, mem_we=1, mem_sel=4'b0011, mem_addr=0x8000_0010, mem_wdata=0xDEAD_BEEF -> MEM granted first with exactly those bus values; then one idle bus cycle; then IF granted; both acks each pulse exactly once.
- IF transaction in flight, flush pulsed for 1 cycle before bus_ack -> bus transaction completes; if_ack stays 0; if_rdata unchanged; next IF request re-fetches normally.
- MEM read with bus_ack never asserted, TIMEOUT=4 -> bus_req drops after 4 wait cycles; bus_err and mem_ack pulse together with mem_rdata=0; FSM back in IDLE two cycles later.
- rst driven low while in MEM_BUS -> bus_req and all outputs go to 0 immediately, before the next clock edge; no ack pulse; a new mem_req after release is granted normally.
- 20 back-to-back mem_req transactions while if_req is held -> the IF request is granted only after mem_req drops; no lost or duplicated acks.
